shift_165_reader: RTL and testbench



---
 rtl/shift_165_if.sv | 41 ++++
 rtl/shift_165_reader.sv | 156 +++++++++++++++
 tb/tb_shift_165_reader.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/shift_165_if.sv
// Bus between shift_165_reader and its surroundings: the 74HC165 chain pins plus the
// parallel result port.
//   scan_req  : request an immediate scan (honoured only while idle)
//   sr_load_n : parallel load strobe to the chain, active low
//   sr_clk    : shift clock to the chain, chain shifts on rising edge
//   sr_data   : serial data from the last device's Q7 (asynchronous)
//   data_out  : last completed scan, first bit shifted in lands in the MSB
//   valid     : one-cycle pulse when data_out updates
//   changed   : one-cycle pulse with valid when data_out differs from its previous value
// The slave modport is the reader; the master modport is the host/board side.
interface shift_165_if #(
  parameter int unsigned NUM_BITS = 16
) ();
  logic                scan_req;
  logic                sr_load_n;
  logic                sr_clk;
  logic                sr_data;
  logic [NUM_BITS-1:0] data_out;
  logic                valid;
  logic                changed;

  modport slave (
    input  scan_req,
    input  sr_data,
    output sr_load_n,
    output sr_clk,
    output data_out,
    output valid,
    output changed
  );

  modport master (
    output scan_req,
    output sr_data,
    input  sr_load_n,
    input  sr_clk,
    input  data_out,
    input  valid,
    input  changed
  );
endinterface

// File: rtl/shift_165_reader.sv
// Periodic scanner for a chain of 74HC165 parallel-in/serial-out shift registers.
// Each scan pulses sr_load_n low, then alternates SAMPLE (capture the synchronized
// serial bit) and CLOCK (sr_clk high) phases of CLK_DIV cycles each, and finally
// publishes the captured word with valid/changed pulses.
// Ports:
//   clk   : fabric clock, rising edge
//   reset : synchronous, active high; aborts a scan in progress
//   bus   : shift_165_if slave modport (chain pins, scan_req, data_out/valid/changed)
module shift_165_reader #(
  parameter int unsigned NUM_BITS  = 16,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned SCAN_IDLE = 1000
) (
  input  logic           clk,
  input  logic           reset,
  shift_165_if.slave     bus
);

  localparam int unsigned PhaseW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam int unsigned IdleW  = (SCAN_IDLE > 1) ? $clog2(SCAN_IDLE) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSample,
    StClock,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [PhaseW-1:0]   phase_q, phase_d;
  logic [BitW-1:0]     bit_q, bit_d;
  logic [IdleW-1:0]    idle_q, idle_d;
  logic [1:0]          sync_q, sync_d;
  logic [NUM_BITS-1:0] shreg_q, shreg_d;
  logic [NUM_BITS-1:0] data_out_q, data_out_d;
  logic                valid_q, valid_d;
  logic                changed_q, changed_d;
  logic                sr_load_n_q, sr_load_n_d;
  logic                sr_clk_q, sr_clk_d;

  logic phase_last;
  assign phase_last = (phase_q == PhaseW'(CLK_DIV - 1));

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    idle_d      = idle_q;
    shreg_d     = shreg_q;
    data_out_d  = data_out_q;
    valid_d     = 1'b0;
    changed_d   = 1'b0;
    sr_load_n_d = sr_load_n_q;
    sr_clk_d    = sr_clk_q;
    // sync_q[1] is the only view of sr_data the FSM ever uses
    sync_d      = {sync_q[0], bus.sr_data};

    // Pin outputs are computed alongside the next state so they change on the same
    // edge as the state and always come straight from flops.
    unique case (state_q)
      StIdle: begin
        if (bus.scan_req || (idle_q == IdleW'(SCAN_IDLE - 1))) begin
          state_d     = StLoad;
          idle_d      = '0;
          phase_d     = '0;
          sr_load_n_d = 1'b0;
          sr_clk_d    = 1'b0;
        end else begin
          idle_d = idle_q + IdleW'(1);
        end
      end
      StLoad: begin
        if (phase_last) begin
          state_d     = StSample;
          phase_d     = '0;
          bit_d       = '0;
          sr_load_n_d = 1'b1;
        end else begin
          phase_d = phase_q + PhaseW'(1);
        end
      end
      StSample: begin
        if (phase_last) begin
          shreg_d = {shreg_q[NUM_BITS-2:0], sync_q[1]};
          phase_d = '0;
          if (bit_q == BitW'(NUM_BITS - 1)) begin
            state_d = StDone;
          end else begin
            bit_d    = bit_q + BitW'(1);
            state_d  = StClock;
            sr_clk_d = 1'b1;
          end
        end else begin
          phase_d = phase_q + PhaseW'(1);
        end
      end
      StClock: begin
        if (phase_last) begin
          state_d  = StSample;
          phase_d  = '0;
          sr_clk_d = 1'b0;
        end else begin
          phase_d = phase_q + PhaseW'(1);
        end
      end
      StDone: begin
        data_out_d = shreg_q;
        valid_d    = 1'b1;
        changed_d  = (shreg_q != data_out_q);
        state_d    = StIdle;
      end
      default: begin
        state_d     = StIdle;
        sr_load_n_d = 1'b1;
        sr_clk_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      phase_q     <= '0;
      bit_q       <= '0;
      idle_q      <= '0;
      sync_q      <= '0;
      shreg_q     <= '0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      changed_q   <= 1'b0;
      sr_load_n_q <= 1'b1;
      sr_clk_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      idle_q      <= idle_d;
      sync_q      <= sync_d;
      shreg_q     <= shreg_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      changed_q   <= changed_d;
      sr_load_n_q <= sr_load_n_d;
      sr_clk_q    <= sr_clk_d;
    end
  end

  assign bus.sr_load_n = sr_load_n_q;
  assign bus.sr_clk    = sr_clk_q;
  assign bus.data_out  = data_out_q;
  assign bus.valid     = valid_q;
  assign bus.changed   = changed_q;

endmodule

// File: tb/tb_shift_165_reader.sv
// Directed bench for shift_165_reader with NUM_BITS=8, CLK_DIV=4, SCAN_IDLE=16 and a
// behavioural 74HC165 chain. Outputs are logged per cycle on the falling edge; cycle 0
// is the first cycle whose ending edge sees reset low.
module tb_shift_165_reader;

  localparam int unsigned NB  = 8;
  localparam int          LOG = 512;

  logic clk;
  logic reset;

  shift_165_if #(.NUM_BITS(NB)) bus ();

  shift_165_reader #(
    .NUM_BITS (NB),
    .CLK_DIV  (4),
    .SCAN_IDLE(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Behavioural 74HC165: asynchronous parallel load, shift on sr_clk rising edge.
  logic [NB-1:0] par_in;
  logic [NB-1:0] chain;
  logic          ovr_en;
  logic          ovr_val;

  always @(posedge bus.sr_clk or negedge bus.sr_load_n) begin
    if (!bus.sr_load_n) chain <= par_in;
    else                chain <= {chain[NB-2:0], 1'b0};
  end

  assign bus.sr_data = ovr_en ? ovr_val : chain[NB-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;
  int cyc;

  logic          ld_log [LOG];
  logic          ck_log [LOG];
  logic          vl_log [LOG];
  logic          ch_log [LOG];
  logic [NB-1:0] do_log [LOG];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    ld_log[cyc] = bus.sr_load_n;
    ck_log[cyc] = bus.sr_clk;
    vl_log[cyc] = bus.valid;
    ch_log[cyc] = bus.changed;
    do_log[cyc] = bus.data_out;
    if (cyc < LOG - 1) cyc++;
  endtask

  task automatic do_reset();
    bus.scan_req = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    cyc = 0;
    tick();
    reset = 1'b0;
  endtask

  function automatic int count_ld_low(input int a, input int b);
    int n = 0;
    for (int c = a; c <= b; c++) if (!ld_log[c]) n++;
    return n;
  endfunction

  function automatic int count_valid(input int a, input int b);
    int n = 0;
    for (int c = a; c <= b; c++) if (vl_log[c]) n++;
    return n;
  endfunction

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    cyc          = 0;
    reset        = 1'b1;
    bus.scan_req = 1'b0;
    ovr_en       = 1'b0;
    ovr_val      = 1'b0;
    chain        = '0;

    // Free-running scans: 0xA5 twice, then 0x5A, 0x01, 0x80.
    par_in = 8'hA5;
    do_reset();
    while (cyc <= 410) begin
      tick();
      if (cyc == 171) par_in = 8'h5A;
      if (cyc == 252) par_in = 8'h01;
      if (cyc == 333) par_in = 8'h80;
    end
    begin
      int bad_ld = 0;
      int rises  = 0;
      int overlap = 0;
      int stray_ch = 0;
      check("rst_load_n", 32'(ld_log[0]), 32'd1);
      check("rst_sr_clk", 32'(ck_log[0]), 32'd0);
      check("rst_valid", 32'(vl_log[0]), 32'd0);
      check("rst_data_out", 32'(do_log[0]), 32'h0);
      for (int c = 0; c <= 96; c++) if (ld_log[c] != !(c >= 16 && c <= 19)) bad_ld++;
      check("load_window_16_19", bad_ld, 0);
      for (int c = 1; c <= 96; c++) if (ck_log[c] && !ck_log[c-1]) rises++;
      check("sr_clk_pulses", rises, 7);
      check("sr_clk_23", 32'(ck_log[23]), 32'd0);
      check("sr_clk_24", 32'(ck_log[24]), 32'd1);
      check("sr_clk_27", 32'(ck_log[27]), 32'd1);
      check("sr_clk_28", 32'(ck_log[28]), 32'd0);
      for (int c = 0; c <= 410; c++) begin
        if (!ld_log[c] && ck_log[c]) overlap++;
        if (ch_log[c] && !vl_log[c]) stray_ch++;
      end
      check("load_clk_overlap", overlap, 0);
      check("changed_without_valid", stray_ch, 0);
      check("valid_80", 32'(vl_log[80]), 32'd0);
      check("valid_81", 32'(vl_log[81]), 32'd1);
      check("valid_82", 32'(vl_log[82]), 32'd0);
      check("changed_81", 32'(ch_log[81]), 32'd1);
      check("data_81", 32'(do_log[81]), 32'hA5);
      check("valid_count", count_valid(0, 410), 5);
      check("valid_162", 32'(vl_log[162]), 32'd1);
      check("changed_162", 32'(ch_log[162]), 32'd0);
      check("data_162", 32'(do_log[162]), 32'hA5);
      check("valid_243", 32'(vl_log[243]), 32'd1);
      check("changed_243", 32'(ch_log[243]), 32'd1);
      check("data_243", 32'(do_log[243]), 32'h5A);
      check("changed_324", 32'(ch_log[324]), 32'd1);
      check("data_324", 32'(do_log[324]), 32'h01);
      check("changed_405", 32'(ch_log[405]), 32'd1);
      check("data_405", 32'(do_log[405]), 32'h80);
    end

    // scan_req in IDLE cycle 5, and again mid-shift at cycle 30 (must be ignored).
    par_in = 8'hA5;
    do_reset();
    while (cyc <= 100) begin
      tick();
      bus.scan_req = (cyc == 6) || (cyc == 31);
    end
    bus.scan_req = 1'b0;
    check("req_ld_5", 32'(ld_log[5]), 32'd1);
    check("req_ld_6", 32'(ld_log[6]), 32'd0);
    check("req_ld_9", 32'(ld_log[9]), 32'd0);
    check("req_ld_10", 32'(ld_log[10]), 32'd1);
    check("req_valid_71", 32'(vl_log[71]), 32'd1);
    check("req_data_71", 32'(do_log[71]), 32'hA5);
    check("req_no_extra_load", count_ld_low(10, 86), 0);
    check("req_next_load_87", 32'(ld_log[87]), 32'd0);
    check("req_valid_count", count_valid(0, 100), 1);

    // One-cycle reset during a CLOCK phase at cycle 50.
    do_reset();
    while (cyc <= 140) begin
      tick();
      reset = (cyc == 51);
    end
    reset = 1'b0;
    check("abort_clk_50", 32'(ck_log[50]), 32'd1);
    check("abort_clk_51", 32'(ck_log[51]), 32'd0);
    check("abort_ld_51", 32'(ld_log[51]), 32'd1);
    check("abort_data_51", 32'(do_log[51]), 32'h0);
    check("abort_no_valid", count_valid(0, 66), 0);
    check("abort_ld_66", 32'(ld_log[66]), 32'd1);
    check("abort_ld_67", 32'(ld_log[67]), 32'd0);
    check("abort_valid_132", 32'(vl_log[132]), 32'd1);
    check("abort_data_132", 32'(do_log[132]), 32'hA5);

    // Synchronizer latency around the first capture edge (end of cycle 23).
    par_in = 8'h00;
    do_reset();
    while (cyc <= 85) begin
      tick();
      if (cyc == 23) begin
        ovr_val = 1'b1;
        ovr_en  = 1'b1;
      end
      if (cyc == 25) ovr_en = 1'b0;
    end
    check("late_toggle_valid", 32'(vl_log[81]), 32'd1);
    check("late_toggle_data", 32'(do_log[81]), 32'h00);
    check("late_toggle_changed", 32'(ch_log[81]), 32'd0);

    do_reset();
    while (cyc <= 85) begin
      tick();
      if (cyc == 21) begin
        ovr_val = 1'b1;
        ovr_en  = 1'b1;
      end
      if (cyc == 25) ovr_en = 1'b0;
    end
    check("early_toggle_data", 32'(do_log[81]), 32'h80);
    check("early_toggle_changed", 32'(ch_log[81]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
